// File: rtl/timer_apb_regif_if.sv
// 8-bit APB-style bus bundle between the CPU bus model (master) and the timer
// register file (slave).
interface timer_apb_regif_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, pslverr);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/timer_apb_regif.sv
// Timer register file (TDR 0x00, TCR 0x01, TSR 0x02) behind an APB-style responder
// with WAIT_STATES extra access cycles. Macro TIMER_APB_PSLVERR_EN flags paddr>0x02 with pslverr.
//
// state  | meaning
// IDLE   | no transfer; waiting for psel with penable low
// SETUP  | setup phase seen; expecting psel and penable high
// ACCESS | wait counter running; pready in the cycle it reaches 0
module timer_apb_regif #(
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] TDR_RST     = 8'h00
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    timer_apb_regif_if.slave bus,
    output logic [7:0]       tdr_o,
    output logic             load_o,
    output logic             updown_o,
    output logic             en_o,
    output logic [1:0]       cks_o,
    input  logic             ovf_set,
    input  logic             udf_set,
    output logic             ovf_o,
    output logic             udf_o
);
    localparam logic [7:0] TCR_MASK = 8'hB3;
    localparam logic [2:0] WS       = 3'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t     state;
    logic [2:0] wait_cnt;
    logic       ready;
    logic [7:0] tdr;
    logic [7:0] tcr;
    logic       ovf;
    logic       udf;

    logic       addr_ok;
    logic       wr_commit;
    logic       tsr_clr_ovf;
    logic       tsr_clr_udf;
    logic [7:0] rdata;

    assign addr_ok     = (bus.paddr <= 8'h02);
    assign wr_commit   = ready && bus.pwrite && addr_ok;
    assign tsr_clr_ovf = wr_commit && (bus.paddr == 8'h02) && bus.pwdata[0];
    assign tsr_clr_udf = wr_commit && (bus.paddr == 8'h02) && bus.pwdata[1];

    // pready is registered, so it is decided one edge ahead of the cycle the counter hits 0.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            ready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (bus.psel && !bus.penable)
                        state <= SETUP;
                end
                SETUP: begin
                    if (bus.psel && bus.penable) begin
                        state    <= ACCESS;
                        wait_cnt <= WS;
                        ready    <= (WS == 3'd0);
                    end else begin
                        state <= IDLE;
                        ready <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 3'd0) begin
                        ready <= 1'b0;
                        state <= (bus.psel && !bus.penable) ? SETUP : IDLE;
                    end else if (!bus.psel) begin
                        state    <= IDLE;
                        wait_cnt <= 3'd0;
                        ready    <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                        ready    <= (wait_cnt == 3'd1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Event set wins over a same-cycle W1C clear.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tdr <= TDR_RST;
            tcr <= 8'h00;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_commit && (bus.paddr == 8'h00))
                tdr <= bus.pwdata;
            if (wr_commit && (bus.paddr == 8'h01))
                tcr <= bus.pwdata & TCR_MASK;
            ovf <= ovf_set || (ovf && !tsr_clr_ovf);
            udf <= udf_set || (udf && !tsr_clr_udf);
        end
    end

    // TSR read includes an event arriving in the pready cycle itself.
    always_comb begin
        rdata = 8'h00;
        case (bus.paddr)
            8'h00:   rdata = tdr;
            8'h01:   rdata = tcr;
            8'h02:   rdata = {6'b000000, udf || udf_set, ovf || ovf_set};
            default: rdata = 8'h00;
        endcase
    end

    assign bus.prdata = ready ? rdata : 8'h00;
    assign bus.pready = ready;
`ifdef TIMER_APB_PSLVERR_EN
    assign bus.pslverr = ready && !addr_ok;
`else
    assign bus.pslverr = 1'b0;
`endif

    assign tdr_o    = tdr;
    assign load_o   = tcr[7];
    assign updown_o = tcr[5];
    assign en_o     = tcr[4];
    assign cks_o    = tcr[1:0];
    assign ovf_o    = ovf;
    assign udf_o    = udf;
endmodule

// File: tb/tb_timer_apb_regif.sv
// Self-checking bench for timer_apb_regif: directed scenarios plus randomized
// transfers against a register-level reference model.
`timescale 1ns/1ps
module tb_timer_apb_regif;
    localparam int WS   = 3;
    localparam int MAXW = 16;
`ifdef TIMER_APB_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       ovf_set = 1'b0;
    logic       udf_set = 1'b0;
    logic [7:0] tdr_o;
    logic       load_o, updown_o, en_o, ovf_o, udf_o;
    logic [1:0] cks_o;

    timer_apb_regif_if bus();

    timer_apb_regif #(.WAIT_STATES(WS), .TDR_RST(8'h00)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .bus      (bus),
        .tdr_o    (tdr_o),
        .load_o   (load_o),
        .updown_o (updown_o),
        .en_o     (en_o),
        .cks_o    (cks_o),
        .ovf_set  (ovf_set),
        .udf_set  (udf_set),
        .ovf_o    (ovf_o),
        .udf_o    (udf_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_tdr, m_tcr;
    logic       m_ovf, m_udf;

    wire [14:0] outs = {tdr_o, load_o, updown_o, en_o, cks_o, ovf_o, udf_o};

    function automatic logic [14:0] model_outs();
        return {m_tdr, m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0], m_ovf, m_udf};
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] addr, input logic eo, input logic eu);
        if (addr == 8'h00) return m_tdr;
        if (addr == 8'h01) return m_tcr;
        if (addr == 8'h02) return {6'b000000, m_udf | eu, m_ovf | eo};
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_tdr = 8'h00; m_tcr = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    // eo/eu are events in the completing cycle: they beat a clear.
    task automatic model_commit(input logic wr, input logic [7:0] addr, input logic [7:0] d,
                                input logic eo, input logic eu);
        logic co, cu;
        co = 1'b0; cu = 1'b0;
        if (wr) begin
            if (addr == 8'h00) m_tdr = d;
            else if (addr == 8'h01) m_tcr = {d[7], 1'b0, d[5], d[4], 2'b00, d[1:0]};
            else if (addr == 8'h02) begin co = d[0]; cu = d[1]; end
        end
        m_ovf = (m_ovf && !co) || eo;
        m_udf = (m_udf && !cu) || eu;
    endtask

    // lat counts cycles after SETUP until pready (-1 if never); event pulsed in cycle ev_cycle.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            input int ev_cycle, input logic ev_o, input logic ev_u,
                            output logic [7:0] rd, output logic err, output int lat, output logic leak);
        bit done;
        done = 0; lat = -1; rd = 8'h00; err = 1'b0; leak = 1'b0;
        @(posedge sys_clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
        @(posedge sys_clk); #1;
        bus.penable = 1'b1;
        for (int i = 1; i <= MAXW && !done; i++) begin
            @(posedge sys_clk); #1;
            ovf_set = (i == ev_cycle) && ev_o;
            udf_set = (i == ev_cycle) && ev_u;
            @(negedge sys_clk);
            if (bus.pready) begin
                done = 1; lat = i; rd = bus.prdata; err = bus.pslverr;
            end else if (bus.prdata !== 8'h00) begin
                leak = 1'b1;
            end
        end
        @(posedge sys_clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; ovf_set = 1'b0; udf_set = 1'b0;
    endtask

    task automatic pulse_event(input logic eo, input logic eu);
        @(posedge sys_clk); #1; ovf_set = eo; udf_set = eu;
        @(posedge sys_clk); #1; ovf_set = 1'b0; udf_set = 1'b0;
        m_ovf = m_ovf || eo;
        m_udf = m_udf || eu;
    endtask

    task automatic test_reset();
        logic [7:0] rd; logic err, leak; int lat;
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        model_reset();
        @(negedge sys_clk);
        checks++;
        if (outs !== model_outs()) begin
            failures++; $display("FAIL reset_outs got=%h exp=%h", outs, model_outs());
        end
        checks++;
        if ({bus.pready, bus.pslverr, bus.prdata} !== 10'h000) begin
            failures++; $display("FAIL reset_bus got=%h exp=000", {bus.pready, bus.pslverr, bus.prdata});
        end
        for (int a = 0; a < 3; a++) begin
            apb_xfer(1'b0, 8'(a), 8'h00, 0, 1'b0, 1'b0, rd, err, lat, leak);
            checks++;
            if (lat != WS + 1) begin
                failures++; $display("FAIL reset_read_latency addr=%0d got=%0d exp=%0d", a, lat, WS + 1);
            end
            checks++;
            if ({rd, err, leak} !== 10'h000) begin
                failures++; $display("FAIL reset_read addr=%0d got rd=%h err=%b leak=%b exp rd=00 err=0 leak=0", a, rd, err, leak);
            end
        end
    endtask

    task automatic test_write_regs();
        logic [7:0] rd; logic err, leak; int lat;
        apb_xfer(1'b1, 8'h00, 8'hA5, 0, 1'b0, 1'b0, rd, err, lat, leak);
        model_commit(1'b1, 8'h00, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (tdr_o !== 8'hA5 || lat != WS + 1) begin
            failures++; $display("FAIL write_tdr got tdr=%h lat=%0d exp tdr=a5 lat=%0d", tdr_o, lat, WS + 1);
        end
        apb_xfer(1'b1, 8'h01, 8'hFF, 0, 1'b0, 1'b0, rd, err, lat, leak);
        model_commit(1'b1, 8'h01, 8'hFF, 1'b0, 1'b0);
        checks++;
        if ({load_o, updown_o, en_o, cks_o} !== 5'b11111) begin
            failures++; $display("FAIL write_tcr_fields got=%b exp=11111", {load_o, updown_o, en_o, cks_o});
        end
        apb_xfer(1'b0, 8'h01, 8'h00, 0, 1'b0, 1'b0, rd, err, lat, leak);
        checks++;
        if (rd !== 8'hB3 || err !== 1'b0) begin
            failures++; $display("FAIL read_tcr got rd=%h err=%b exp rd=b3 err=0", rd, err);
        end
        checks++;
        if (outs !== model_outs()) begin
            failures++; $display("FAIL write_regs_outs got=%h exp=%h", outs, model_outs());
        end
    endtask

    task automatic test_status();
        logic [7:0] rd; logic err, leak; int lat;
        pulse_event(1'b1, 1'b0);
        checks++;
        if (ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf_o); end
        apb_xfer(1'b0, 8'h02, 8'h00, 0, 1'b0, 1'b0, rd, err, lat, leak);
        checks++;
        if (rd !== 8'h01) begin failures++; $display("FAIL tsr_read_ovf got=%h exp=01", rd); end
        apb_xfer(1'b1, 8'h02, 8'h00, 0, 1'b0, 1'b0, rd, err, lat, leak);
        checks++;
        if (ovf_o !== 1'b1) begin failures++; $display("FAIL tsr_write0_noeffect got=%b exp=1", ovf_o); end
        apb_xfer(1'b1, 8'h02, 8'h01, 0, 1'b0, 1'b0, rd, err, lat, leak);
        model_commit(1'b1, 8'h02, 8'h01, 1'b0, 1'b0);
        checks++;
        if (ovf_o !== 1'b0) begin failures++; $display("FAIL ovf_w1c got=%b exp=0", ovf_o); end
        pulse_event(1'b0, 1'b1);
        apb_xfer(1'b1, 8'h02, 8'h02, WS + 1, 1'b0, 1'b1, rd, err, lat, leak);
        model_commit(1'b1, 8'h02, 8'h02, 1'b0, 1'b1);
        checks++;
        if (udf_o !== 1'b1) begin failures++; $display("FAIL udf_set_beats_clear got=%b exp=1", udf_o); end
        apb_xfer(1'b1, 8'h02, 8'h02, 0, 1'b0, 1'b0, rd, err, lat, leak);
        model_commit(1'b1, 8'h02, 8'h02, 1'b0, 1'b0);
        checks++;
        if (udf_o !== 1'b0) begin failures++; $display("FAIL udf_w1c got=%b exp=0", udf_o); end
        apb_xfer(1'b0, 8'h02, 8'h00, WS + 1, 1'b1, 1'b0, rd, err, lat, leak);
        model_commit(1'b0, 8'h02, 8'h00, 1'b1, 1'b0);
        checks++;
        if (rd !== 8'h01) begin failures++; $display("FAIL tsr_same_cycle_event got=%h exp=01", rd); end
        checks++;
        if (outs !== model_outs()) begin
            failures++; $display("FAIL status_outs got=%h exp=%h", outs, model_outs());
        end
    endtask

    task automatic test_invalid();
        logic [7:0] rd; logic err, leak; int lat;
        logic [7:0] bad [3];
        bad = '{8'h03, 8'h05, 8'hFF};
        for (int k = 0; k < 3; k++) begin
            apb_xfer(1'b1, bad[k], 8'h55, 0, 1'b0, 1'b0, rd, err, lat, leak);
            checks++;
            if (err !== ERR_EN || lat != WS + 1 || outs !== model_outs()) begin
                failures++; $display("FAIL invalid_write addr=%h got err=%b lat=%0d outs=%h exp err=%b lat=%0d outs=%h",
                                     bad[k], err, lat, outs, ERR_EN, WS + 1, model_outs());
            end
            apb_xfer(1'b0, bad[k], 8'h00, 0, 1'b0, 1'b0, rd, err, lat, leak);
            checks++;
            if (rd !== 8'h00 || err !== ERR_EN) begin
                failures++; $display("FAIL invalid_read addr=%h got rd=%h err=%b exp rd=00 err=%b", bad[k], rd, err, ERR_EN);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] rd; logic err, leak; int lat;
        logic saw_ready;
        saw_ready = 1'b0;
        @(posedge sys_clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'h00; bus.pwdata = 8'h77;
        @(posedge sys_clk); #1;
        bus.penable = 1'b1;
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        saw_ready = bus.pready;
        @(posedge sys_clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            saw_ready = saw_ready | bus.pready;
        end
        checks++;
        if (saw_ready !== 1'b0) begin failures++; $display("FAIL abort_pready got=1 exp=0"); end
        checks++;
        if (tdr_o !== m_tdr) begin failures++; $display("FAIL abort_tdr got=%h exp=%h", tdr_o, m_tdr); end
        apb_xfer(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, rd, err, lat, leak);
        checks++;
        if (lat != WS + 1 || rd !== m_tdr) begin
            failures++; $display("FAIL abort_recover got lat=%0d rd=%h exp lat=%0d rd=%h", lat, rd, WS + 1, m_tdr);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd; logic err, leak; int lat;
        logic saw_ready;
        saw_ready = 1'b0;
        @(posedge sys_clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'h01; bus.pwdata = 8'hFF;
        @(posedge sys_clk); #1;
        bus.penable = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        model_reset();
        // psel/penable held high after reset: penable in IDLE must be ignored
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            saw_ready = saw_ready | bus.pready;
        end
        @(posedge sys_clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        checks++;
        if (saw_ready !== 1'b0) begin failures++; $display("FAIL reset_mid_pready got=1 exp=0"); end
        checks++;
        if (outs !== model_outs()) begin
            failures++; $display("FAIL reset_mid_outs got=%h exp=%h", outs, model_outs());
        end
        apb_xfer(1'b0, 8'h01, 8'h00, 0, 1'b0, 1'b0, rd, err, lat, leak);
        checks++;
        if (rd !== 8'h00 || lat != WS + 1) begin
            failures++; $display("FAIL reset_mid_tcr got rd=%h lat=%0d exp rd=00 lat=%0d", rd, lat, WS + 1);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, addr, data, exp_rd; logic err, leak, wr, eo, eu, eo_now, eu_now, exp_err; int lat, evc, r;
        for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom_range(0, 1));
            r    = $urandom_range(0, 5);
            addr = (r <= 2) ? 8'(r) : 8'($urandom_range(3, 255));
            data = 8'($urandom);
            evc  = $urandom_range(0, WS + 1);
            eo   = 1'($urandom_range(0, 1));
            eu   = 1'($urandom_range(0, 1));
            if (evc >= 1 && evc <= WS) begin
                m_ovf = m_ovf || eo;
                m_udf = m_udf || eu;
            end
            eo_now  = (evc == WS + 1) && eo;
            eu_now  = (evc == WS + 1) && eu;
            exp_rd  = wr ? 8'h00 : model_read(addr, eo_now, eu_now);
            exp_err = ERR_EN && (addr > 8'h02);
            apb_xfer(wr, addr, data, evc, eo, eu, rd, err, lat, leak);
            model_commit(wr, addr, data, eo_now, eu_now);
            checks++;
            if (lat != WS + 1 || err !== exp_err || leak !== 1'b0) begin
                failures++; $display("FAIL rand_handshake n=%0d got lat=%0d err=%b leak=%b exp lat=%0d err=%b leak=0",
                                     n, lat, err, leak, WS + 1, exp_err);
            end
            if (!wr) begin
                checks++;
                if (rd !== exp_rd) begin
                    failures++; $display("FAIL rand_read n=%0d addr=%h got=%h exp=%h", n, addr, rd, exp_rd);
                end
            end
            checks++;
            if (outs !== model_outs()) begin
                failures++; $display("FAIL rand_outs n=%0d got=%h exp=%h", n, outs, model_outs());
            end
        end
    endtask

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 8'h00; bus.pwdata = 8'h00;
        model_reset();
        test_reset();
        test_write_regs();
        test_status();
        test_invalid();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
